// File: rtl/bg_region_mapper.sv
// Two-stage pixel-to-region mapper with shadowed, scrollable windows.
// Table commits and scroll advances happen on frame_tick.
module bg_region_mapper #(
  parameter int NUM_REGIONS = 3,
  parameter int COORD_W     = 10,
  parameter int ADDR_W      = 19,
  parameter int ID_W        = $clog2(NUM_REGIONS + 1)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               pix_valid,
  input  logic               cfg_we,
  input  logic [ID_W-1:0]    cfg_idx,
  input  logic [COORD_W-1:0] cfg_x_pos,
  input  logic [COORD_W-1:0] cfg_y_pos,
  input  logic [COORD_W-1:0] cfg_x_size,
  input  logic [COORD_W-1:0] cfg_y_size,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [COORD_W-1:0] cfg_scroll_step,
  output logic [ADDR_W-1:0]  bg_read_address,
  output logic [ID_W-1:0]    is_bg,
  output logic               out_valid
);

  localparam int CW = COORD_W;
  localparam int PW = ADDR_W + 2 * COORD_W + 1;

  typedef struct packed {
    logic [CW-1:0]     xp;
    logic [CW-1:0]     yp;
    logic [CW-1:0]     xs;
    logic [CW-1:0]     ys;
    logic [ADDR_W-1:0] base;
    logic [CW-1:0]     step;
  } win_t;

  win_t              sh_q   [NUM_REGIONS];
  win_t              act_q  [NUM_REGIONS];
  logic [CW-1:0]     off_q  [NUM_REGIONS];
  logic [CW-1:0]     off_d  [NUM_REGIONS];
  logic [CW-1:0]     rx_d   [NUM_REGIONS];
  logic [CW-1:0]     ry_d   [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] hit_d;

  logic [NUM_REGIONS-1:0] s1_hit_q;
  logic [CW-1:0]     s1_rx_q   [NUM_REGIONS];
  logic [CW-1:0]     s1_ry_q   [NUM_REGIONS];
  logic [CW-1:0]     s1_xs_q   [NUM_REGIONS];
  logic [ADDR_W-1:0] s1_base_q [NUM_REGIONS];
  logic              s1_vld_q;

  win_t cfg_w;
  assign cfg_w = '{xp: cfg_x_pos, yp: cfg_y_pos, xs: cfg_x_size,
                   ys: cfg_y_size, base: cfg_base, step: cfg_scroll_step};

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_reg
    logic [CW:0] step_e, sum, sum_w, xe, ye, rs, ys1;
    assign ys1    = {1'b0, act_q[g].ys};
    // A step not smaller than the window height would skip whole frames
    assign step_e = (act_q[g].step < act_q[g].ys) ? {1'b0, act_q[g].step} : '0;
    assign sum    = {1'b0, off_q[g]} + step_e;
    assign sum_w  = (sum >= ys1) ? sum - ys1 : sum;
    assign off_d[g] = (sh_q[g].ys != act_q[g].ys) ? '0 : sum_w[CW-1:0];

    assign xe = {1'b0, act_q[g].xp} + {1'b0, act_q[g].xs};
    assign ye = {1'b0, act_q[g].yp} + ys1;
    assign hit_d[g] = (|act_q[g].xs) && (|act_q[g].ys) &&
                      ({1'b0, DrawX} >= {1'b0, act_q[g].xp}) &&
                      ({1'b0, DrawX} < xe) &&
                      ({1'b0, DrawY} >= {1'b0, act_q[g].yp}) &&
                      ({1'b0, DrawY} < ye);
    assign rx_d[g] = DrawX - act_q[g].xp;
    assign rs      = {1'b0, DrawY - act_q[g].yp} + {1'b0, off_q[g]};
    assign ry_d[g] = (rs >= ys1) ? CW'(rs - ys1) : rs[CW-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        sh_q[i]  <= '0;
        act_q[i] <= '0;
        off_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (frame_tick) begin
          act_q[i] <= sh_q[i];
          off_q[i] <= off_d[i];
        end
        if (cfg_we && cfg_idx == ID_W'(i + 1)) begin
          sh_q[i] <= cfg_w;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_hit_q <= '0;
      s1_vld_q <= 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        s1_rx_q[i]   <= '0;
        s1_ry_q[i]   <= '0;
        s1_xs_q[i]   <= '0;
        s1_base_q[i] <= '0;
      end
    end else begin
      s1_hit_q <= hit_d;
      s1_vld_q <= pix_valid;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        s1_rx_q[i]   <= rx_d[i];
        s1_ry_q[i]   <= ry_d[i];
        s1_xs_q[i]   <= act_q[i].xs;
        s1_base_q[i] <= act_q[i].base;
      end
    end
  end

  logic [ID_W-1:0]   id_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] sel_base;
  logic [CW-1:0]     sel_rx, sel_ry, sel_xs;

  // Descending scan so the lowest-index hit is the last one written
  always_comb begin
    id_d     = '0;
    sel_base = '0;
    sel_rx   = '0;
    sel_ry   = '0;
    sel_xs   = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (s1_hit_q[i]) begin
        id_d     = ID_W'(i + 1);
        sel_base = s1_base_q[i];
        sel_rx   = s1_rx_q[i];
        sel_ry   = s1_ry_q[i];
        sel_xs   = s1_xs_q[i];
      end
    end
    addr_d = ADDR_W'(PW'(sel_base) + PW'(sel_ry) * PW'(sel_xs) + PW'(sel_rx));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      is_bg           <= '0;
      bg_read_address <= '0;
      out_valid       <= 1'b0;
    end else begin
      is_bg           <= id_d;
      bg_read_address <= addr_d;
      out_valid       <= s1_vld_q;
    end
  end

endmodule

// File: tb/tb_bg_region_mapper.sv
// Bench for bg_region_mapper: directed tables, corner sequences and
// random traffic checked against a frame-level reference model.
module tb_bg_region_mapper;

  localparam int NR = 3;
  localparam int CW = 10;
  localparam int AW = 19;
  localparam int IW = 2;

  logic          Clk = 1'b0;
  logic          Reset, frame_tick, pix_valid, cfg_we;
  logic [CW-1:0] DrawX, DrawY;
  logic [IW-1:0] cfg_idx;
  logic [CW-1:0] cfg_x_pos, cfg_y_pos, cfg_x_size, cfg_y_size, cfg_scroll_step;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] bg_read_address;
  logic [IW-1:0] is_bg;
  logic          out_valid;

  bg_region_mapper dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x_pos(cfg_x_pos), .cfg_y_pos(cfg_y_pos),
    .cfg_x_size(cfg_x_size), .cfg_y_size(cfg_y_size),
    .cfg_base(cfg_base), .cfg_scroll_step(cfg_scroll_step),
    .bg_read_address(bg_read_address), .is_bg(is_bg),
    .out_valid(out_valid)
  );

  always #5 Clk = ~Clk;

  typedef struct { int xp, yp, xs, ys, base, step; } win_t;
  typedef struct { int id; int addr; int v; } res_t;
  typedef struct { int x, y, id, addr; } vec_t;

  win_t sh  [1:NR];
  win_t act [1:NR];
  int   off [1:NR];
  res_t p1, p2;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   chk = 0;

  function automatic res_t ref_map(int x, int y, int v);
    res_t r;
    r = '{0, 0, v};
    for (int k = 1; k <= NR; k++) begin
      if (act[k].xs > 0 && act[k].ys > 0 &&
          x >= act[k].xp && x < act[k].xp + act[k].xs &&
          y >= act[k].yp && y < act[k].yp + act[k].ys) begin
        int t;
        longint a;
        t = (y - act[k].yp) + off[k];
        if (t >= act[k].ys) t -= act[k].ys;
        a = longint'(act[k].base) + longint'(t) * act[k].xs + (x - act[k].xp);
        r.id = k;
        r.addr = int'(a % (longint'(1) << AW));
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 1; k <= NR; k++) begin
      sh[k]  = '{default: 0};
      act[k] = '{default: 0};
      off[k] = 0;
    end
  endtask

  task automatic model_tick();
    int se, s;
    for (int k = 1; k <= NR; k++) begin
      se = (act[k].step < act[k].ys) ? act[k].step : 0;
      s  = off[k] + se;
      if (s >= act[k].ys) s -= act[k].ys;
      if (sh[k].ys != act[k].ys) s = 0;
      off[k] = s;
      act[k] = sh[k];
    end
  endtask

  task automatic cycle();
    res_t e;
    e = ref_map(int'(DrawX), int'(DrawY), int'(pix_valid));
    @(posedge Clk);
    if (Reset) begin
      model_clear();
      p1 = '{0, 0, 0};
      p2 = '{0, 0, 0};
    end else begin
      p2 = p1;
      p1 = e;
      if (frame_tick) model_tick();
      if (cfg_we && cfg_idx >= 1 && int'(cfg_idx) <= NR)
        sh[int'(cfg_idx)] = '{xp: int'(cfg_x_pos), yp: int'(cfg_y_pos),
                              xs: int'(cfg_x_size), ys: int'(cfg_y_size),
                              base: int'(cfg_base), step: int'(cfg_scroll_step)};
    end
    #1;
    cyc++;
    if (chk) begin
      n_cmp++;
      if (is_bg !== IW'(p2.id) || bg_read_address !== AW'(p2.addr) ||
          out_valid !== 1'(p2.v)) begin
        n_err++;
        $display("FAIL pipe cyc %0d: got id=%0d addr=%0d v=%0b want id=%0d addr=%0d v=%0d",
                 cyc, is_bg, bg_read_address, out_valid, p2.id, p2.addr, p2.v);
      end
    end
  endtask

  task automatic chk_eq(string nm, int got, int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic wr(int idx, int xp, int yp, int xs, int ys, int base,
                    int step, bit tk);
    cfg_we = 1'b1;
    cfg_idx = IW'(idx);
    cfg_x_pos = CW'(xp);
    cfg_y_pos = CW'(yp);
    cfg_x_size = CW'(xs);
    cfg_y_size = CW'(ys);
    cfg_base = AW'(base);
    cfg_scroll_step = CW'(step);
    frame_tick = tk;
    cycle();
    cfg_we = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
  endtask

  task automatic probe(int x, int y, output int id, output int addr);
    DrawX = CW'(x);
    DrawY = CW'(y);
    pix_valid = 1'b1;
    cycle();
    pix_valid = 1'b0;
    cycle();
    id = int'(is_bg);
    addr = int'(bg_read_address);
  endtask

  task automatic legacy();
    wr(1, 0, 0, 320, 480, 0, 0, 1'b0);
    wr(2, 320, 0, 320, 240, 0, 0, 1'b0);
    wr(3, 320, 240, 320, 240, 0, 0, 1'b0);
    tick();
  endtask

  initial begin
    vec_t tv [5];
    int id, addr;

    tv[0] = '{319, 479, 1, 153599};
    tv[1] = '{320, 0, 2, 0};
    tv[2] = '{320, 240, 3, 0};
    tv[3] = '{639, 479, 3, 76799};
    tv[4] = '{640, 0, 0, 0};

    Reset = 1'b1; frame_tick = 1'b0; pix_valid = 1'b0; cfg_we = 1'b0;
    DrawX = '0; DrawY = '0; cfg_idx = '0;
    cfg_x_pos = '0; cfg_y_pos = '0; cfg_x_size = '0; cfg_y_size = '0;
    cfg_base = '0; cfg_scroll_step = '0;
    model_clear();
    p1 = '{0, 0, 0};
    p2 = '{0, 0, 0};
    cycle();
    chk = 1;
    cycle();
    Reset = 1'b0;
    chk_eq("rst_valid", int'(out_valid), 0);
    chk_eq("rst_id", int'(is_bg), 0);
    chk_eq("rst_addr", int'(bg_read_address), 0);

    legacy();
    for (int i = 0; i < 5; i++) begin
      DrawX = CW'(tv[i].x);
      DrawY = CW'(tv[i].y);
      pix_valid = 1'b1;
      cycle();
      pix_valid = 1'b0;
      chk_eq($sformatf("lat1_v[%0d]", i), int'(out_valid), 0);
      cycle();
      chk_eq($sformatf("lat2_v[%0d]", i), int'(out_valid), 1);
      chk_eq($sformatf("leg_id[%0d]", i), int'(is_bg), tv[i].id);
      chk_eq($sformatf("leg_addr[%0d]", i), int'(bg_read_address), tv[i].addr);
    end

    do_reset();
    legacy();
    wr(1, 0, 0, 320, 480, 1000, 0, 1'b0);
    probe(0, 0, id, addr);
    chk_eq("shadow_pre", addr, 0);
    tick();
    probe(0, 0, id, addr);
    chk_eq("shadow_post", addr, 1000);
    wr(1, 0, 0, 320, 480, 2000, 0, 1'b1);
    probe(0, 0, id, addr);
    chk_eq("shadow_coinc", addr, 1000);
    tick();
    probe(0, 0, id, addr);
    chk_eq("shadow_next", addr, 2000);

    do_reset();
    legacy();
    wr(1, 0, 0, 320, 480, 0, 10, 1'b0);
    tick();
    tick();
    probe(0, 475, id, addr);
    chk_eq("scroll_1", addr, 1600);
    repeat (47) tick();
    probe(0, 475, id, addr);
    chk_eq("scroll_wrap", addr, 152000);
    wr(1, 0, 0, 320, 480, 0, 480, 1'b0);
    tick();
    probe(0, 475, id, addr);
    chk_eq("scroll_big_a", addr, 1600);
    tick();
    probe(0, 475, id, addr);
    chk_eq("scroll_big_b", addr, 1600);

    do_reset();
    legacy();
    wr(2, 0, 0, 320, 480, 5000, 0, 1'b0);
    tick();
    probe(10, 10, id, addr);
    chk_eq("prio_id", id, 1);
    chk_eq("prio_addr", addr, 3210);
    wr(1, 0, 0, 320, 0, 0, 0, 1'b0);
    tick();
    probe(10, 10, id, addr);
    chk_eq("prio2_id", id, 2);
    chk_eq("prio2_addr", addr, 8210);

    do_reset();
    legacy();
    for (int x = 0; x < 640; x++) begin
      DrawX = CW'(x);
      DrawY = '0;
      pix_valid = (x % 2 == 0);
      Reset = (x == 400);
      cycle();
      if (x == 400) begin
        chk_eq("mid_rst_v", int'(out_valid), 0);
        chk_eq("mid_rst_id", int'(is_bg), 0);
        chk_eq("mid_rst_addr", int'(bg_read_address), 0);
      end else if (x > 402) begin
        chk_eq("post_rst_id", int'(is_bg), 0);
      end
    end
    Reset = 1'b0;
    pix_valid = 1'b0;

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      Reset = ($urandom_range(0, 199) == 0);
      frame_tick = ($urandom_range(0, 19) == 0);
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_idx = IW'($urandom_range(0, 3));
      cfg_x_pos = CW'($urandom_range(0, 700));
      cfg_y_pos = CW'($urandom_range(0, 700));
      cfg_x_size = CW'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 400));
      cfg_y_size = CW'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 400));
      cfg_base = AW'($urandom);
      cfg_scroll_step = CW'($urandom_range(0, 420));
      DrawX = CW'($urandom_range(0, 1023));
      DrawY = CW'($urandom_range(0, 1023));
      pix_valid = $urandom_range(0, 1) == 1;
      cycle();
    end
    Reset = 1'b0;
    frame_tick = 1'b0;
    cfg_we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
